idct_transpose_buffer: RTL and testbench
========================================

Name: idct_transpose_buffer

Overview:
- Row/column corner-turn between the two 1-D IDCT passes of the 2-D 8x8 IDCT.
- Accepts eight 8-wide rows from the row-pass IDCT (one row per beat, no backpressure honoured upstream beyond in_ready) and emits the same block as eight columns to the column-pass IDCT.
- Ping-pong double buffer: one bank fills while the other drains, so back-to-back blocks stream at one beat per cycle.

Parameters:
- DATA_WIDTH, 64, signed sample width of every row/column element.
- BLK_DIM, 8, block dimension. Fixed at 8; other values are unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  row_in/channel_in carry a valid row this cycle
- channel_in  in  2  component id (Y/Cb/Cr) of the row
- row_in  in  DATA_WIDTH x 8 (signed, [7:0])  row elements; index = column position
- in_ready  out  1  buffer can accept a row this cycle
- col_out  out  DATA_WIDTH x 8 (signed, [7:0])  column elements; index = row position
- channel_out  out  2  component id of the block being drained
- valid_out  out  1  col_out/channel_out valid
- last_out  out  1  col_out is column 7 of the block
- out_ready  in  1  downstream accepts the column this cycle

Behaviour:
- Reset (async assert, sync release): both bank-full flags=0, wr_bank=0, rd_bank=0, wr_row=0, rd_col=0, latched channels=0.
  - Outputs during reset: in_ready=1, valid_out=0, last_out=0, channel_out=0, col_out=0.
  - Bank data contents need not be cleared.
- Write side:
  - A row is accepted when valid_in && in_ready; it is stored as bank[wr_bank][wr_row][0..7].
  - wr_row is a 3-bit counter that increments on every accept.
  - channel_in is latched into the bank's channel register on row 0 only. channel_in on rows 1..7 is ignored.
  - On accept of row 7: full[wr_bank]<=1, wr_bank toggles, wr_row wraps to 0.
  - in_ready = !full[wr_bank], purely from registers.
  - valid_in while in_ready=0 is dropped. The upstream IDCT has no stall, so system integration must guarantee this never happens; the bench flags it as an error.
- Read side:
  - valid_out = full[rd_bank].
  - col_out[r] = bank[rd_bank][r][rd_col] for r=0..7.
  - channel_out = latched channel of rd_bank.
  - last_out = valid_out && (rd_col==7).
  - A column transfers when valid_out && out_ready; rd_col then increments.
  - On transfer of column 7: full[rd_bank]<=0, rd_bank toggles, rd_col wraps to 0.
  - Outputs are held stable while valid_out && !out_ready.
- Latency:
  - First column is valid the cycle after row 7 is accepted (1 cycle).
  - Minimum row-7-accept to column-7-transfer is 8 cycles.
  - Sustained throughput is 1 beat/cycle with out_ready=1.
- Simultaneous events:
  - Row-7 accept on one bank and column-7 transfer on the other bank in the same cycle: both flag updates apply.
  - The two sides never address the same bank in the same cycle, so there is no read/write collision.
- Full: both banks full gives in_ready=0 until the next column-7 transfer. in_ready rises in the cycle after that transfer.
- Empty: both banks empty gives valid_out=0. col_out is don't-care; the bench must not check it.
- Reset mid-block: a partial block and any undrained blocks are discarded. No output beat follows reset until 8 new rows have been accepted.
- Arithmetic: none. Pure storage and reordering, bit-exact, sign preserved.

Decomposition:
- Shared package jpeg_idct_pkg holds:
  - localparam BLK_DIM=8 and default DATA_WIDTH=64
  - typedef channel_t (logic [1:0])
  - typedef row_idx_t (logic [2:0])
- One sub-module, transpose_bank: a single 8x8 register bank with a row-write port (we, row index, 8 elements) and a column-read port (column index, 8 elements).
- idct_transpose_buffer instantiates two transpose_banks and contains the ping-pong control, counters and channel latches.

Test Plan:
- Single block, out_ready=1: rows r=0..7 with row_in[c]=8r+c, channel_in=1 -> 8 beats, beat k has col_out[r]=8r+k (e.g. beat 0 = 0,8,...,56), channel_out=1 throughout, last_out only on beat 7, first valid_out one cycle after row 7 is accepted.
- Back-to-back streaming: 3 blocks with 24 consecutive valid rows (values 100*blk+8r+c, channels 0,1,2), out_ready=1 -> in_ready stays 1, 24 contiguous output beats, correct channel per block, no gaps after the initial fill.
- Backpressure: out_ready toggled 1,0,0,1,... during drain -> col_out/channel_out/last_out stable while stalled, no column lost or duplicated.
- Full stall: out_ready=0, 16 rows fed -> in_ready drops to 0 the cycle after row 15 is accepted. Then raise out_ready -> in_ready returns to 1 the cycle after column 7 of block 0 transfers.
- Channel latch and signs: row 0 with channel 2, rows 1..7 with channel 0, elements include -1 and -(2^40) -> channel_out=2 on every beat, negative values reproduced bit-exact.
- Reset mid-operation: assert rst after 5 rows (and separately during a stalled drain) -> valid_out=0 and in_ready=1 immediately. A following full block outputs only new data.

Source files
------------

// File: rtl/jpeg_idct_pkg.sv
// Shared types and constants for the 2-D IDCT datapath.
package jpeg_idct_pkg;
  localparam int BLK_DIM            = 8;
  localparam int DEFAULT_DATA_WIDTH = 64;

  typedef logic [1:0] channel_t;
  typedef logic [2:0] row_idx_t;

  localparam row_idx_t LAST_IDX = row_idx_t'(BLK_DIM - 1);
endpackage

// File: rtl/transpose_bank.sv
// One 8x8 sample bank: written a whole row at a time, read a whole column at a time.
module transpose_bank
  import jpeg_idct_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         we,
  input  row_idx_t                     wr_row,
  input  logic signed [DATA_WIDTH-1:0] wr_data [BLK_DIM-1:0],
  input  row_idx_t                     rd_col,
  output logic signed [DATA_WIDTH-1:0] rd_data [BLK_DIM-1:0]
);

  logic signed [DATA_WIDTH-1:0] mem [BLK_DIM][BLK_DIM];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < BLK_DIM; c++) begin
        mem[wr_row][c] <= wr_data[c];
      end
    end
  end

  // Column read is combinational so a freshly filled bank is visible the next cycle.
  genvar gi;
  generate
    for (gi = 0; gi < BLK_DIM; gi++) begin : g_rd
      assign rd_data[gi] = mem[gi][rd_col];
    end
  endgenerate

endmodule

// File: rtl/idct_transpose_buffer.sv
// Ping-pong corner-turn between the row and column IDCT passes.
module idct_transpose_buffer
  import jpeg_idct_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  channel_t                     channel_in,
  input  logic signed [DATA_WIDTH-1:0] row_in [BLK_DIM-1:0],
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] col_out [BLK_DIM-1:0],
  output channel_t                     channel_out,
  output logic                         valid_out,
  output logic                         last_out,
  input  logic                         out_ready
);

  logic [1:0] full_reg;
  logic [1:0] full_next;
  logic       wr_bank_reg;
  logic       rd_bank_reg;
  row_idx_t   wr_row_reg;
  row_idx_t   rd_col_reg;
  channel_t   chan_reg [2];
  logic       accept;
  logic       xfer;

  logic signed [DATA_WIDTH-1:0] bank_col [2][BLK_DIM-1:0];

  assign in_ready    = !full_reg[wr_bank_reg];
  assign valid_out   = full_reg[rd_bank_reg];
  assign accept      = valid_in && in_ready;
  assign xfer        = valid_out && out_ready;
  assign last_out    = valid_out && (rd_col_reg == LAST_IDX);
  assign channel_out = chan_reg[rd_bank_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      transpose_bank #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_bank (
        .clk    (clk),
        .we     (accept && (wr_bank_reg == 1'(gi))),
        .wr_row (wr_row_reg),
        .wr_data(row_in),
        .rd_col (rd_col_reg),
        .rd_data(bank_col[gi])
      );
    end

    // Output forced to zero while empty so reset and idle never expose stale data.
    for (gi = 0; gi < BLK_DIM; gi++) begin : g_col
      assign col_out[gi] = valid_out ? bank_col[rd_bank_reg][gi] : '0;
    end
  endgenerate

  // Write and read sides always own different banks, so both updates may land together.
  always_comb begin
    full_next = full_reg;
    if (accept && (wr_row_reg == LAST_IDX)) full_next[wr_bank_reg] = 1'b1;
    if (xfer && (rd_col_reg == LAST_IDX))   full_next[rd_bank_reg] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg    <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_row_reg  <= '0;
      rd_col_reg  <= '0;
      chan_reg[0] <= '0;
      chan_reg[1] <= '0;
    end else begin
      full_reg <= full_next;
      if (accept) begin
        wr_row_reg <= wr_row_reg + 1'b1;
        if (wr_row_reg == '0)       chan_reg[wr_bank_reg] <= channel_in;
        if (wr_row_reg == LAST_IDX) wr_bank_reg <= !wr_bank_reg;
      end
      if (xfer) begin
        rd_col_reg <= rd_col_reg + 1'b1;
        if (rd_col_reg == LAST_IDX) rd_bank_reg <= !rd_bank_reg;
      end
    end
  end

endmodule

// File: tb/tb_idct_transpose_buffer.sv
// Bench for idct_transpose_buffer: queue-of-beats reference model, randomized and directed traffic.
module tb_idct_transpose_buffer;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [1:0]    channel_in;
  logic signed [DW-1:0] row_in  [7:0];
  logic          in_ready;
  logic signed [DW-1:0] col_out [7:0];
  logic [1:0]    channel_out;
  logic          valid_out;
  logic          last_out;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;

  // Reference model: every completed block becomes 8 expected beats, queued in output order.
  typedef struct packed {
    logic [1:0]          ch;
    logic [7:0][DW-1:0]  col;
  } beat_t;

  beat_t         beat_q[$];
  logic [DW-1:0] part [8][8];
  logic [1:0]    part_ch;
  int            part_rows;

  always #5 clk = ~clk;

  idct_transpose_buffer #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .channel_in (channel_in),
    .row_in     (row_in),
    .in_ready   (in_ready),
    .col_out    (col_out),
    .channel_out(channel_out),
    .valid_out  (valid_out),
    .last_out   (last_out),
    .out_ready  (out_ready)
  );

  function automatic int pend();
    return (beat_q.size() + 7) / 8;
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    beat_q.delete();
    part_rows = 0;
    part_ch   = '0;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sees at the edge.
  task automatic cycle();
    bit acc, xf;
    beat_t b;
    if (valid_in) begin
      checks++;
      if (!in_ready) begin
        failures++;
        $display("FAIL dropped_row t=%0t valid_in=1 while in_ready=%b required in_ready=1", $time, in_ready);
      end
    end
    acc = valid_in && (pend() < 2);
    xf  = (beat_q.size() > 0) && out_ready;
    @(posedge clk);
    if (xf) void'(beat_q.pop_front());
    if (acc) begin
      for (int c = 0; c < 8; c++) part[part_rows][c] = row_in[c];
      if (part_rows == 0) part_ch = channel_in;
      part_rows++;
      if (part_rows == 8) begin
        for (int k = 0; k < 8; k++) begin
          b.ch = part_ch;
          for (int r = 0; r < 8; r++) b.col[r] = part[r][k];
          beat_q.push_back(b);
        end
        part_rows = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid_in   = 1'b0;
    channel_in = '0;
    for (int c = 0; c < 8; c++) row_in[c] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || valid_out !== 1'b0 || last_out !== 1'b0 || channel_out !== 2'd0) begin
      failures++;
      $display("FAIL reset_flags in_ready=%b valid_out=%b last_out=%b channel_out=%0d required 1 0 0 0",
               in_ready, valid_out, last_out, channel_out);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (col_out[r] !== 64'sd0) begin
        failures++;
        $display("FAIL reset_col col_out[%0d]=%h required 0", r, col_out[r]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    int bad, beats;
    beats = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      checks++;
      if (valid_out !== (beat_q.size() > 0) || in_ready !== (pend() < 2) || last_out !== (beat_q.size() % 8 == 1)) begin
        failures++;
        $display("FAIL single_flags t=%0t valid/ready/last=%b%b%b required %b%b%b", $time, valid_out, in_ready, last_out,
                 beat_q.size() > 0, pend() < 2, beat_q.size() % 8 == 1);
      end else if (valid_out) begin
        beats++;
        checks++;
        bad = 0;
        for (int r = 0; r < 8; r++) if (col_out[r] !== beat_q[0].col[r]) bad = r + 1;
        if (bad != 0 || channel_out !== beat_q[0].ch) begin
          failures++;
          $display("FAIL single_beat t=%0t elem=%0d got %h ch %0d required %h ch %0d", $time, bad,
                   col_out[(bad == 0) ? 0 : bad - 1], channel_out, beat_q[0].col[(bad == 0) ? 0 : bad - 1], beat_q[0].ch);
        end
      end
      if (cyc == 8) begin
        checks++;
        if (valid_out !== 1'b1 || col_out[1] !== 64'sd8 || channel_out !== 2'd1) begin
          failures++;
          $display("FAIL single_first valid_out=%b col_out[1]=%0d ch=%0d required 1 8 1", valid_out, col_out[1], channel_out);
        end
      end
      if (cyc == 15) begin
        checks++;
        if (last_out !== 1'b1 || col_out[7] !== 64'sd63) begin
          failures++;
          $display("FAIL single_last last_out=%b col_out[7]=%0d required 1 63", last_out, col_out[7]);
        end
      end
      if (cyc < 8) begin
        valid_in   = 1'b1;
        channel_in = 2'd1;
        for (int c = 0; c < 8; c++) row_in[c] = 64'(8 * cyc + c);
      end else idle_inputs();
      cycle();
    end
    checks++;
    if (beats != 8) begin
      failures++;
      $display("FAIL single_count beats=%0d required 8", beats);
    end
  endtask

  task automatic test_back_to_back();
    int bad, first, lastv, beats;
    first = -1; lastv = -1; beats = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      checks++;
      if (valid_out !== (beat_q.size() > 0) || in_ready !== 1'b1 || last_out !== (beat_q.size() % 8 == 1)) begin
        failures++;
        $display("FAIL b2b_flags t=%0t valid/ready/last=%b%b%b required %b1%b", $time, valid_out, in_ready, last_out,
                 beat_q.size() > 0, beat_q.size() % 8 == 1);
      end else if (valid_out) begin
        beats++;
        if (first < 0) first = cyc;
        lastv = cyc;
        checks++;
        bad = 0;
        for (int r = 0; r < 8; r++) if (col_out[r] !== beat_q[0].col[r]) bad = r + 1;
        if (bad != 0 || channel_out !== beat_q[0].ch) begin
          failures++;
          $display("FAIL b2b_beat t=%0t elem=%0d got %0d ch %0d required %0d ch %0d", $time, bad,
                   col_out[(bad == 0) ? 0 : bad - 1], channel_out, beat_q[0].col[(bad == 0) ? 0 : bad - 1], beat_q[0].ch);
        end
      end
      if (cyc < 24) begin
        valid_in   = 1'b1;
        channel_in = 2'(cyc / 8);
        for (int c = 0; c < 8; c++) row_in[c] = 64'(100 * (cyc / 8) + 8 * (cyc % 8) + c);
      end else idle_inputs();
      cycle();
    end
    checks++;
    if (beats != 24 || lastv - first != 23) begin
      failures++;
      $display("FAIL b2b_stream beats=%0d span=%0d required 24 23", beats, lastv - first);
    end
  endtask

  task automatic test_backpressure();
    int bad, xfers;
    logic prev_hold;
    logic [7:0][DW-1:0] prev_col;
    logic [1:0] prev_ch;
    logic prev_last;
    xfers = 0; prev_hold = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      checks++;
      if (valid_out !== (beat_q.size() > 0) || in_ready !== (pend() < 2) || last_out !== (beat_q.size() % 8 == 1)) begin
        failures++;
        $display("FAIL bp_flags t=%0t valid/ready/last=%b%b%b required %b%b%b", $time, valid_out, in_ready, last_out,
                 beat_q.size() > 0, pend() < 2, beat_q.size() % 8 == 1);
      end else if (valid_out) begin
        checks++;
        bad = 0;
        for (int r = 0; r < 8; r++) if (col_out[r] !== beat_q[0].col[r]) bad = r + 1;
        if (bad != 0 || channel_out !== beat_q[0].ch) begin
          failures++;
          $display("FAIL bp_beat t=%0t elem=%0d got %h required %h", $time, bad,
                   col_out[(bad == 0) ? 0 : bad - 1], beat_q[0].col[(bad == 0) ? 0 : bad - 1]);
        end
      end
      if (prev_hold) begin
        checks++;
        bad = 0;
        for (int r = 0; r < 8; r++) if (col_out[r] !== prev_col[r]) bad = r + 1;
        if (bad != 0 || channel_out !== prev_ch || last_out !== prev_last || valid_out !== 1'b1) begin
          failures++;
          $display("FAIL bp_hold t=%0t elem=%0d valid_out=%b ch=%0d last=%b required held values ch=%0d last=%b",
                   $time, bad, valid_out, channel_out, last_out, prev_ch, prev_last);
        end
      end
      if (cyc < 8) begin
        valid_in   = 1'b1;
        channel_in = 2'($urandom_range(0, 2));
        for (int c = 0; c < 8; c++) row_in[c] = rnd64();
      end else idle_inputs();
      out_ready = (cyc % 3 == 0);
      for (int r = 0; r < 8; r++) prev_col[r] = col_out[r];
      prev_ch   = channel_out;
      prev_last = last_out;
      prev_hold = valid_out && !out_ready;
      if (valid_out && out_ready) xfers++;
      cycle();
    end
    checks++;
    if (xfers != 8) begin
      failures++;
      $display("FAIL bp_count transfers=%0d required 8", xfers);
    end
  endtask

  task automatic test_full_stall();
    int bad;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      checks++;
      if (valid_out !== (beat_q.size() > 0) || in_ready !== (pend() < 2) || last_out !== (beat_q.size() % 8 == 1)) begin
        failures++;
        $display("FAIL stall_flags t=%0t valid/ready/last=%b%b%b required %b%b%b", $time, valid_out, in_ready, last_out,
                 beat_q.size() > 0, pend() < 2, beat_q.size() % 8 == 1);
      end else if (valid_out) begin
        checks++;
        bad = 0;
        for (int r = 0; r < 8; r++) if (col_out[r] !== beat_q[0].col[r]) bad = r + 1;
        if (bad != 0 || channel_out !== beat_q[0].ch) begin
          failures++;
          $display("FAIL stall_beat t=%0t elem=%0d got %h required %h", $time, bad,
                   col_out[(bad == 0) ? 0 : bad - 1], beat_q[0].col[(bad == 0) ? 0 : bad - 1]);
        end
      end
      if (cyc == 16 || cyc == 26) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_full cyc=%0d in_ready=%b required 0", cyc, in_ready);
        end
      end
      if (cyc == 27) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL stall_release in_ready=%b required 1", in_ready);
        end
      end
      if (cyc < 16) begin
        valid_in   = 1'b1;
        channel_in = 2'($urandom_range(0, 2));
        for (int c = 0; c < 8; c++) row_in[c] = rnd64();
      end else idle_inputs();
      out_ready = (cyc >= 19);
      cycle();
    end
  endtask

  task automatic test_signs();
    int bad;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      checks++;
      if (valid_out !== (beat_q.size() > 0) || in_ready !== (pend() < 2) || last_out !== (beat_q.size() % 8 == 1)) begin
        failures++;
        $display("FAIL sign_flags t=%0t valid/ready/last=%b%b%b required %b%b%b", $time, valid_out, in_ready, last_out,
                 beat_q.size() > 0, pend() < 2, beat_q.size() % 8 == 1);
      end else if (valid_out) begin
        checks++;
        bad = 0;
        for (int r = 0; r < 8; r++) if (col_out[r] !== beat_q[0].col[r]) bad = r + 1;
        if (bad != 0 || channel_out !== 2'd2 || col_out[cyc - 8] !== -64'sd1 || col_out[15 - cyc] !== -(64'sd1 <<< 40)) begin
          failures++;
          $display("FAIL sign_beat t=%0t elem=%0d ch=%0d diag=%0d anti=%0d required ch 2 diag -1 anti %0d", $time, bad,
                   channel_out, col_out[cyc - 8], col_out[15 - cyc], -(64'sd1 <<< 40));
        end
      end
      if (cyc < 8) begin
        valid_in   = 1'b1;
        channel_in = (cyc == 0) ? 2'd2 : 2'd0;
        for (int c = 0; c < 8; c++) begin
          if (c == cyc)          row_in[c] = -64'sd1;
          else if (c == 7 - cyc) row_in[c] = -(64'sd1 <<< 40);
          else                   row_in[c] = rnd64();
        end
      end else idle_inputs();
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    int bad, beats;
    for (int pass = 0; pass < 2; pass++) begin
      out_ready = 1'b0;
      for (int cyc = 0; cyc < ((pass == 0) ? 5 : 10); cyc++) begin
        if (cyc < 8) begin
          valid_in   = 1'b1;
          channel_in = 2'd3;
          for (int c = 0; c < 8; c++) row_in[c] = rnd64();
        end else idle_inputs();
        out_ready = (pass == 1) && (cyc == 8);
        cycle();
      end
      idle_inputs();
      rst = 1'b1;
      #1;
      checks++;
      if (valid_out !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL midrst_async pass=%0d valid_out=%b in_ready=%b required 0 1", pass, valid_out, in_ready);
      end
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      beats = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 22; cyc++) begin
        checks++;
        if (valid_out !== (beat_q.size() > 0) || in_ready !== (pend() < 2) || last_out !== (beat_q.size() % 8 == 1)) begin
          failures++;
          $display("FAIL midrst_flags t=%0t valid/ready/last=%b%b%b required %b%b%b", $time, valid_out, in_ready, last_out,
                   beat_q.size() > 0, pend() < 2, beat_q.size() % 8 == 1);
        end else if (valid_out) begin
          beats++;
          checks++;
          bad = 0;
          for (int r = 0; r < 8; r++) if (col_out[r] !== beat_q[0].col[r]) bad = r + 1;
          if (bad != 0 || channel_out !== beat_q[0].ch) begin
            failures++;
            $display("FAIL midrst_beat t=%0t elem=%0d got %h required %h", $time, bad,
                     col_out[(bad == 0) ? 0 : bad - 1], beat_q[0].col[(bad == 0) ? 0 : bad - 1]);
          end
        end
        if (cyc >= 2 && cyc < 10) begin
          valid_in   = 1'b1;
          channel_in = 2'd1;
          for (int c = 0; c < 8; c++) row_in[c] = rnd64();
        end else idle_inputs();
        cycle();
      end
      checks++;
      if (beats != 8) begin
        failures++;
        $display("FAIL midrst_count pass=%0d beats=%0d required 8", pass, beats);
      end
    end
  endtask

  task automatic test_random();
    int bad;
    for (int cyc = 0; cyc < 500; cyc++) begin
      checks++;
      if (valid_out !== (beat_q.size() > 0) || in_ready !== (pend() < 2) || last_out !== (beat_q.size() % 8 == 1)) begin
        failures++;
        $display("FAIL rand_flags t=%0t valid/ready/last=%b%b%b required %b%b%b", $time, valid_out, in_ready, last_out,
                 beat_q.size() > 0, pend() < 2, beat_q.size() % 8 == 1);
      end else if (valid_out) begin
        checks++;
        bad = 0;
        for (int r = 0; r < 8; r++) if (col_out[r] !== beat_q[0].col[r]) bad = r + 1;
        if (bad != 0 || channel_out !== beat_q[0].ch) begin
          failures++;
          $display("FAIL rand_beat t=%0t elem=%0d got %h ch %0d required %h ch %0d", $time, bad,
                   col_out[(bad == 0) ? 0 : bad - 1], channel_out, beat_q[0].col[(bad == 0) ? 0 : bad - 1], beat_q[0].ch);
        end
      end
      valid_in   = (pend() < 2) && ($urandom_range(0, 3) != 0);
      channel_in = 2'($urandom_range(0, 3));
      for (int c = 0; c < 8; c++) row_in[c] = rnd64();
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_full_stall();
    test_signs();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
